// File: rtl/cache_trace_feeder.sv
// Deterministic address trace source for the cache hit-counting model, one address per ready/updated handshake.
// Optional build macro CACHE_TRACE_LFSR_EN replaces the strided address sequence with a 16-bit LFSR walk.
module cache_trace_feeder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned STRIDE    = 4,
    parameter int unsigned NUM_ADDRS = 16,
    parameter int unsigned PASSES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        updated,
    output logic [31:0] mem_addr,
    output logic        trace_ready,
    output logic        done,
    output logic [15:0] issued_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [11:0] LAST_IDX  = 12'(NUM_ADDRS - 1);
    localparam logic [3:0]  LAST_PASS = 4'(PASSES - 1);

`ifdef CACHE_TRACE_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [31:0] lfsr_addr(input logic [15:0] s);
        return BASE_ADDR + {14'b0, s, 2'b00};
    endfunction

    logic [15:0] lfsr_q, lfsr_d;
`else
    localparam logic [31:0] STRIDE_W = 32'(STRIDE);
`endif

    state_t      state_q, state_d;
    logic [11:0] idx_q, idx_d;
    logic [3:0]  pass_q, pass_d;
    logic [15:0] issued_q, issued_d;
    logic [31:0] addr_q, addr_d;
    logic        last_addr;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        issued_d  = issued_q;
        addr_d    = addr_q;
`ifdef CACHE_TRACE_LFSR_EN
        lfsr_d    = lfsr_q;
`endif
        last_addr = (idx_q == LAST_IDX) && (pass_q == LAST_PASS);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = ISSUE;
                    idx_d    = '0;
                    pass_d   = '0;
                    issued_d = '0;
`ifdef CACHE_TRACE_LFSR_EN
                    lfsr_d   = LFSR_SEED;
                    addr_d   = lfsr_addr(LFSR_SEED);
`else
                    addr_d   = BASE_ADDR;
`endif
                end
            end
            ISSUE: begin
                if (updated) begin
                    issued_d = issued_q + 16'd1;
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        pass_d = pass_q + 4'd1;
                    end else begin
                        idx_d  = idx_q + 12'd1;
                    end
`ifdef CACHE_TRACE_LFSR_EN
                    lfsr_d = lfsr_step(lfsr_q);
`endif
                    // The final address stays on mem_addr while in DONE.
                    if (last_addr) begin
                        state_d = DONE;
                    end else begin
                        state_d = GAP;
`ifdef CACHE_TRACE_LFSR_EN
                        addr_d  = lfsr_addr(lfsr_step(lfsr_q));
`else
                        addr_d  = (idx_q == LAST_IDX) ? BASE_ADDR : addr_q + STRIDE_W;
`endif
                    end
                end
            end
            GAP: begin
                state_d = ISSUE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pass_q   <= '0;
            issued_q <= '0;
`ifdef CACHE_TRACE_LFSR_EN
            lfsr_q   <= LFSR_SEED;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pass_q   <= pass_d;
            issued_q <= issued_d;
`ifdef CACHE_TRACE_LFSR_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    // Address register is data only; the IDLE gating below keeps mem_addr at 0 after reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    assign trace_ready  = (state_q == ISSUE);
    assign done         = (state_q == DONE);
    assign mem_addr     = (state_q == IDLE) ? 32'h0 : addr_q;
    assign issued_count = issued_q;

endmodule

// File: tb/tb_cache_trace_feeder.sv
// Self-checking bench for cache_trace_feeder: run-level reference model checked every cycle plus directed literals.
module tb_cache_trace_feeder;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int          STRIDE = 4;
    localparam int          N      = 16;
    localparam int          P      = 2;
    localparam int          TOTAL  = N * P;
`ifdef CACHE_TRACE_LFSR_EN
    localparam logic [31:0] FIRST_ADDR = 32'h0002_C384;
`else
    localparam logic [31:0] FIRST_ADDR = 32'h0000_1000;
`endif

    logic        clk = 1'b0;
    logic        rst, start, upd;
    logic [31:0] mem_addr;
    logic        trace_ready, done;
    logic [15:0] issued_count;

    logic        w_start, w_upd;
    logic [31:0] w_addr;
    logic        w_ready, w_done;
    logic [15:0] w_issued;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cache_trace_feeder #(
        .BASE_ADDR(BASE), .STRIDE(STRIDE), .NUM_ADDRS(N), .PASSES(P)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .updated(upd),
        .mem_addr(mem_addr), .trace_ready(trace_ready), .done(done),
        .issued_count(issued_count)
    );

    cache_trace_feeder #(
        .BASE_ADDR(32'hFFFF_FFF8), .STRIDE(4), .NUM_ADDRS(4), .PASSES(1)
    ) dut_wrap (
        .clk(clk), .reset(rst), .start(w_start), .updated(w_upd),
        .mem_addr(w_addr), .trace_ready(w_ready), .done(w_done),
        .issued_count(w_issued)
    );

    // k-th accepted address of a run (k counts across passes).
    function automatic logic [31:0] exp_addr(input int k);
`ifdef CACHE_TRACE_LFSR_EN
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return BASE + {14'b0, s, 2'b00};
`else
        return BASE + 32'((k % N) * STRIDE);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Run-level model: running/gap/done flags plus the number of accepted addresses.
    bit m_active = 1'b0, m_gap = 1'b0, m_done = 1'b0;
    int m_acc = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0; m_gap <= 1'b0; m_done <= 1'b0; m_acc <= 0;
        end else if (!m_active && start) begin
            m_active <= 1'b1; m_gap <= 1'b0; m_done <= 1'b0; m_acc <= 0;
        end else if (m_active) begin
            if (m_gap) begin
                m_gap <= 1'b0;
            end else if (upd) begin
                m_acc <= m_acc + 1;
                if (m_acc + 1 == TOTAL) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_gap <= 1'b1;
                end
            end
        end
    end

    logic exp_ready;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_ready = m_active && !m_gap;
            chk("trace_ready", {31'b0, trace_ready}, {31'b0, exp_ready});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("issued_count", {16'b0, issued_count}, {16'b0, m_acc[15:0]});
            if (exp_ready)       chk("mem_addr issue", mem_addr, exp_addr(m_acc));
            else if (m_done)     chk("mem_addr done", mem_addr, exp_addr(m_acc - 1));
            else if (!m_active)  chk("mem_addr idle", mem_addr, 32'h0);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) begin
            errors++;
            $display("FAIL wait_done: timeout after %0d cycles, required done=1", budget);
        end
    endtask

    logic [31:0] wrap_exp [4];
    int cyc;

    initial begin
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        rst = 1'b1; start = 1'b0; upd = 1'b0; w_start = 1'b0; w_upd = 1'b1;

        // Reset held for 3 cycles, then 20 idle cycles with no start.
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset issued_count", {16'b0, issued_count}, 32'h0);
        chk("reset done", {31'b0, done}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle trace_ready", {31'b0, trace_ready}, 32'h0);
        end

        // Full run with updated tied high.
        upd = 1'b1;
        pulse_start();
        chk("start latency ready", {31'b0, trace_ready}, 32'h1);
        chk("first addr", mem_addr, FIRST_ADDR);
        wait_done(200, cyc);
        chk("run length", 32'(cyc), 32'd63);
        chk("run final count", {16'b0, issued_count}, 32'd32);
`ifndef CACHE_TRACE_LFSR_EN
        chk("run last addr", mem_addr, 32'h0000_103C);
`endif

        // Spurious updated while in DONE.
        repeat (3) @(negedge clk);
        upd = 1'b0;
        @(negedge clk);
        upd = 1'b1;
        @(negedge clk);
        chk("spurious done count", {16'b0, issued_count}, 32'd32);

`ifdef CACHE_TRACE_LFSR_EN
        pulse_start();
        chk("lfsr first addr", mem_addr, 32'h0002_C384);
        repeat (2) @(negedge clk);
        chk("lfsr second addr", mem_addr, 32'h0001_69C0);
        wait_done(200, cyc);
`endif

        // Backpressure: updated every 5th cycle, pulses also land in GAP.
        upd = 1'b0;
        pulse_start();
        cyc = 0;
        while (!done && cyc < 1000) begin
            upd = (cyc % 5 == 4);
            @(negedge clk);
            cyc++;
        end
        upd = 1'b0;
        chk("backpressure done", {31'b0, done}, 32'h1);
        chk("backpressure count", {16'b0, issued_count}, 32'd32);

        // Reset after 7 acceptances.
        upd = 1'b1;
        pulse_start();
        cyc = 0;
        while (issued_count != 16'd7 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrun reached 7", {16'b0, issued_count}, 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun reset ready", {31'b0, trace_ready}, 32'h0);
        chk("midrun reset count", {16'b0, issued_count}, 32'h0);
        chk("midrun reset addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        pulse_start();
        chk("restart addr", mem_addr, FIRST_ADDR);
        chk("restart count", {16'b0, issued_count}, 32'h0);
        wait_done(200, cyc);
        chk("restart final count", {16'b0, issued_count}, 32'd32);

        // Address wrap past 32'hFFFF_FFFF on the second instance.
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
`ifndef CACHE_TRACE_LFSR_EN
        for (int i = 0; i < 4; i++) begin
            chk("wrap ready", {31'b0, w_ready}, 32'h1);
            chk("wrap addr", w_addr, wrap_exp[i]);
            @(negedge clk);
            if (i < 3) @(negedge clk);
        end
`else
        chk("wrap lfsr first addr", w_addr, 32'h0002_B37C);
        repeat (7) @(negedge clk);
`endif
        chk("wrap done", {31'b0, w_done}, 32'h1);
        chk("wrap count", {16'b0, w_issued}, 32'd4);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
